spi_rx_slave: RTL and testbench
===============================

Name: spi_rx_slave

Overview:
Receiving end of the single-wire, clk-synchronous serial link driven by the team's byte transmitter. The transmitter drives ss low and mosi with one data bit per clk, LSB first. This block samples mosi on every clk edge while ss is low and assembles DATA_W-bit words. Completed words are buffered in a small first-word-fall-through FIFO with a valid/ready read port, and framing and overflow errors are reported as pulses.

Parameters:
DATA_W, 8, word width in bits; equals bits per frame.
FIFO_DEPTH, 4, receive buffer entries; power of two, >= 2.
LSB_FIRST, 1, 1 = first sampled bit is bit 0; 0 = first sampled bit is bit DATA_W-1.

Ports:
clk  in  1  system clock; all sampling on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
ss  in  1  slave select, active-low; same clock domain, no synchronizer.
mosi  in  1  serial data, valid on any edge where ss=0.
dout  out  DATA_W  FIFO head word; 0 when FIFO is empty.
dv  out  1  high when FIFO is non-empty.
rdy  in  1  consumer accept; pop occurs on an edge where dv=1 and rdy=1.
frame_err  out  1  one-cycle pulse: ss rose with a partial word pending.
overflow  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
fifo_cnt  out  $clog2(FIFO_DEPTH+1)  number of stored words.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit_cnt=0, shift register=0, FIFO emptied. dout=0, dv=0, frame_err=0, overflow=0, fifo_cnt=0. Reset mid-frame discards the partial word. The first edge after release behaves as IDLE.
- States:
  - IDLE: ss=1 and bit_cnt=0.
  - SHIFT: ss=0, receiving.
- IDLE -> SHIFT: on an edge with ss=0, sample mosi as the first bit and set bit_cnt=1.
- In SHIFT, each edge with ss=0:
  - Sample mosi into position bit_cnt, or DATA_W-1-bit_cnt when LSB_FIRST=0.
  - Increment bit_cnt.
- Word completion: on the edge that samples bit number DATA_W-1, the full word (including that bit) is pushed on the same edge and bit_cnt returns to 0.
  - If ss stays low, the next edge starts a new word. Back-to-back words need no gap.
- SHIFT -> IDLE:
  - On an edge with ss=1 and bit_cnt=0: clean end of frame, no error.
  - On an edge with ss=1 and bit_cnt!=0: frame_err=1 for exactly one cycle; partial word discarded; bit_cnt=0.
- Latency: the last bit is sampled at edge N. dv and dout reflect the word from cycle N+1 if the FIFO was empty.
- FIFO push/pop:
  - Pop and push may occur on the same edge.
  - fifo_cnt updates +1, -1, or 0 accordingly.
  - Pop when empty is impossible, since dv=0.
- Full FIFO with push:
  - Without a simultaneous pop: the new word is dropped, overflow=1 for one cycle, contents unchanged.
  - With a simultaneous pop: both operations complete, no overflow, fifo_cnt stays FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_cnt.
- dout is combinational from the head entry, or 0 when empty. All other outputs are registered.
- frame_err and overflow can pulse on the same cycle only in the event combinations defined above; each is independent.

Test Plan:
- Send 0xA5 LSB-first (ss low 8 cycles, mosi 1,0,1,0,0,1,0,1), rdy=1 -> dv=1 with dout=0xA5 on the cycle after the 8th bit; popped next edge; fifo_cnt 1 -> 0; no error pulses.
- ss low 16 cycles carrying 0x3C then 0xC3, rdy=0 -> fifo_cnt=2, dout=0x3C; raise rdy -> dout 0x3C then 0xC3, then dv=0 and dout=0.
- ss low for 5 bits then high -> frame_err pulses one cycle, fifo_cnt unchanged; next frame 0x81 received correctly.
- rdy=0, send 5 words 0x01..0x05 with FIFO_DEPTH=4 -> fifo_cnt=4, overflow pulses once at the 5th completion; draining yields 0x01..0x04.
- FIFO full, rdy=1 held on the completion edge of 0x77 -> no overflow, fifo_cnt stays 4, 0x77 is the last word drained.
- Assert rst_n low after 3 bits of a frame -> all outputs 0 immediately; after release, frame 0x5A received correctly, no frame_err.

Source files
------------

// File: rtl/spi_rx_slave.sv
// Serial receive slave: samples mosi every clk while ss is low, assembles
// DATA_W-bit words and queues them in a first-word-fall-through FIFO.
module spi_rx_slave #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ss,
  input  logic                               mosi,
  output logic [DATA_W-1:0]                  dout,
  output logic                               dv,
  input  logic                               rdy,
  output logic                               frame_err,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt
);

  // state | meaning
  // IDLE  | ss high, no partial word pending
  // SHIFT | ss low, receiving bits
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t             state_q, state_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]    bit_idx;
  logic [DATA_W-1:0]  shift_q, shift_d, word;
  logic               push, frame_err_d;
  logic               frame_err_q, overflow_q, dv_q;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full, pop, wr_en;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    // A fresh word starts from zero so no stale bits leak in.
    word        = (bit_cnt_q == '0) ? '0 : shift_q;
    bit_idx     = (LSB_FIRST != 0) ? bit_cnt_q : BC_W'(DATA_W - 1) - bit_cnt_q;
    word[bit_idx] = mosi;
    if (!ss) begin
      state_d = SHIFT;
      if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
        push      = 1'b1;
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = word;
      end
    end else begin
      state_d     = IDLE;
      frame_err_d = (state_q == SHIFT) && (bit_cnt_q != '0);
      bit_cnt_d   = '0;
      shift_d     = '0;
    end
  end

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop   = dv_q & rdy;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      dv_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dv_q        <= (cnt_d != '0);
      frame_err_q <= frame_err_d;
      overflow_q  <= push & full & ~pop;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign dout      = dv_q ? mem_q[rd_ptr_q] : '0;
  assign dv        = dv_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_spi_rx_slave.sv
// Directed bench for spi_rx_slave: framing, FIFO ordering, overflow and reset.
module tb_spi_rx_slave;
  logic       clk = 1'b0;
  logic       rst_n, ss, mosi, rdy;
  logic [7:0] dout;
  logic       dv, frame_err, overflow;
  logic [2:0] fifo_cnt;
  int         checks = 0;
  int         errors = 0;

  spi_rx_slave #(.DATA_W(8), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .mosi(mosi), .dout(dout), .dv(dv),
    .rdy(rdy), .frame_err(frame_err), .overflow(overflow), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmit one word LSB first; ss left low. Optionally raise rdy on the last bit only.
  task automatic send_word(input logic [7:0] w, input bit pop_last);
    for (int i = 0; i < 8; i++) begin
      ss   = 1'b0;
      mosi = w[i];
      if (pop_last && i == 7) rdy = 1'b1;
      tick();
    end
    if (pop_last) rdy = 1'b0;
  endtask

  task automatic end_frame();
    ss = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss = 1'b1; mosi = 1'b0; rdy = 1'b0;
    #12;
    checks++;
    if ({dout, dv, frame_err, overflow, fifo_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got dout=%h dv=%b fe=%b ov=%b cnt=%0d want all 0",
               dout, dv, frame_err, overflow, fifo_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rdy = 1'b1;
    send_word(8'hA5, 1'b0);
    checks++;
    if (dv !== 1'b1 || dout !== 8'hA5 || fifo_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_head got dv=%b dout=%h cnt=%0d want 1 a5 1", dv, dout, fifo_cnt);
    end
    end_frame();
    checks++;
    if (dv !== 1'b0 || dout !== 8'h00 || fifo_cnt !== 3'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got dv=%b dout=%h cnt=%0d fe=%b ov=%b want 0 00 0 0 0",
               dv, dout, fifo_cnt, frame_err, overflow);
    end
    rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, 1'b0);
    send_word(8'hC3, 1'b0);
    end_frame();
    checks++;
    if (fifo_cnt !== 3'd2 || dout !== 8'h3C || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stored got cnt=%0d dout=%h fe=%b want 2 3c 0", fifo_cnt, dout, frame_err);
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (dout !== 8'hC3 || fifo_cnt !== 3'd1) begin
      errors++;
      $display("FAIL b2b_second got dout=%h cnt=%0d want c3 1", dout, fifo_cnt);
    end
    tick();
    checks++;
    if (dv !== 1'b0 || dout !== 8'h00 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL b2b_empty got dv=%b dout=%h cnt=%0d want 0 00 0", dv, dout, fifo_cnt);
    end
    rdy = 1'b0;
  endtask

  task automatic test_frame_err();
    for (int i = 0; i < 5; i++) begin
      ss = 1'b0; mosi = 1'b1;
      tick();
    end
    end_frame();
    checks++;
    if (frame_err !== 1'b1 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL frame_err_pulse got fe=%b cnt=%0d want 1 0", frame_err, fifo_cnt);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_width got fe=%b want 0", frame_err);
    end
    send_word(8'h81, 1'b0);
    end_frame();
    checks++;
    if (dout !== 8'h81 || fifo_cnt !== 3'd1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_after_err got dout=%h cnt=%0d fe=%b want 81 1 0", dout, fifo_cnt, frame_err);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
    checks++;
    if (fifo_cnt !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill got cnt=%0d ov=%b want 4 0", fifo_cnt, overflow);
    end
    send_word(8'h05, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fifo_cnt !== 3'd4) begin
      errors++;
      $display("FAIL ovf_pulse got ov=%b cnt=%0d want 1 4", overflow, fifo_cnt);
    end
    end_frame();
    checks++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_width got ov=%b fe=%b want 0 0", overflow, frame_err);
    end
    rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (dout !== 8'(k) || dv !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain%0d got dout=%h dv=%b want %h 1", k, dout, dv, 8'(k));
      end
      tick();
    end
    checks++;
    if (dv !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL ovf_empty got dv=%b cnt=%0d want 0 0", dv, fifo_cnt);
    end
    rdy = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [4];
    exp[0] = 8'h12; exp[1] = 8'h13; exp[2] = 8'h14; exp[3] = 8'h77;
    for (int k = 0; k < 4; k++) send_word(8'h11 + 8'(k), 1'b0);
    send_word(8'h77, 1'b1);
    checks++;
    if (overflow !== 1'b0 || fifo_cnt !== 3'd4 || dout !== 8'h12) begin
      errors++;
      $display("FAIL fullpop got ov=%b cnt=%0d dout=%h want 0 4 12", overflow, fifo_cnt, dout);
    end
    end_frame();
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout !== exp[k]) begin
        errors++;
        $display("FAIL fullpop_drain%0d got dout=%h want %h", k, dout, exp[k]);
      end
      tick();
    end
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_word(8'h42, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ss = 1'b0; mosi = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dv, frame_err, overflow, fifo_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid got dout=%h dv=%b fe=%b ov=%b cnt=%0d want all 0",
               dout, dv, frame_err, overflow, fifo_cnt);
    end
    ss = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    tick();
    send_word(8'h5A, 1'b0);
    end_frame();
    checks++;
    if (dout !== 8'h5A || fifo_cnt !== 3'd1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover got dout=%h cnt=%0d fe=%b want 5a 1 0", dout, fifo_cnt, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
